// File: rtl/joypad_target_pkg.sv
// Shared definitions for the two-wire joypad link: responder states, default
// link address and the fixed order of the payload bytes.
package joypad_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX,
        MACK,
        IGNORE
    } link_state_e;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h52;

    localparam logic [1:0] BYTE_P1     = 2'd0;
    localparam logic [1:0] BYTE_P2     = 2'd1;
    localparam logic [1:0] BYTE_STATUS = 2'd2;
    localparam logic [1:0] BYTE_COUNT  = 2'd3;

    // Only reads are supported, so a match needs the R/W bit set as well.
    function automatic logic addr_is_read_match(input logic [7:0] addr_byte,
                                                input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && addr_byte[0];
    endfunction

endpackage

// File: rtl/joypad_target_line_sync_edge.sv
// Multi-stage synchronizer for one link wire followed by a history flop that
// yields single-cycle rise/fall strobes on the synchronized level.
module line_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], line_in};
        hist_d = sync_q[STAGES-1];
    end

    // Reset to the released (high) bus level so no edge appears on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign line_sync = sync_q[STAGES-1];
    assign rise      = line_sync & ~hist_q;
    assign fall      = ~line_sync & hist_q;

endmodule

// File: rtl/joypad_target.sv
// Controller-side responder: answers reads at TARGET_ADDR with a snapshot of
// P1 buttons, P2 buttons, presence flags and a running transaction count.
module joypad_target
    import joypad_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] buttons_p1,
    input  logic [7:0] buttons_p2,
    input  logic [1:0] present,
    output logic       busy
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;
    logic start_det, stop_det;

    line_sync_edge #(.STAGES(SYNC_N)) u_scl_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (scl_in),
        .line_sync (scl_s),
        .rise      (scl_rise),
        .fall      (scl_fall)
    );

    line_sync_edge #(.STAGES(SYNC_N)) u_sda_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (sda_in),
        .line_sync (sda_s),
        .rise      (sda_rise),
        .fall      (sda_fall)
    );

    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    link_state_e     state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      count_q, count_d;
    logic            busy_q, busy_d;
    logic            sda_out_q, sda_out_d;
    logic            ack_drv_q, ack_drv_d;
    logic [6:0]      shift_q, shift_d;
    logic [3:0][7:0] snap_q, snap_d;
    logic [17:0]     pad_meta_q, pad_meta_d;
    logic [17:0]     pad_sync_q, pad_sync_d;
    logic [7:0]      addr_byte;
    logic [2:0]      tx_idx;

    // Button pads are asynchronous; bring them into clk before snapshotting.
    always_comb begin
        pad_meta_d = {present, buttons_p2, buttons_p1};
        pad_sync_d = pad_meta_q;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        count_d    = count_q;
        busy_d     = busy_q;
        sda_out_d  = sda_out_q;
        ack_drv_d  = ack_drv_q;
        shift_d    = shift_q;
        snap_d     = snap_q;
        addr_byte  = {shift_q, sda_s};
        tx_idx     = 3'd7 - bit_cnt_q[2:0];

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
            ack_drv_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
            ack_drv_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_out_d = 1'b1;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = addr_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (addr_is_read_match(addr_byte, TARGET_ADDR)) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    // First fall starts the ACK low; the second ends it and puts out bit 7.
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            sda_out_d           = 1'b0;
                            ack_drv_d           = 1'b1;
                            snap_d[BYTE_P1]     = pad_sync_q[7:0];
                            snap_d[BYTE_P2]     = pad_sync_q[15:8];
                            snap_d[BYTE_STATUS] = {6'b0, pad_sync_q[17:16]};
                            snap_d[BYTE_COUNT]  = count_q;
                            count_d             = count_q + 8'd1;
                            byte_idx_d          = BYTE_P1;
                        end else begin
                            ack_drv_d = 1'b0;
                            state_d   = TX;
                            sda_out_d = snap_q[BYTE_P1][7];
                            bit_cnt_d = 4'd1;
                        end
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q[3]) begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = MACK;
                        end else begin
                            sda_out_d = snap_q[byte_idx_q][tx_idx];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                MACK: begin
                    // Index wraps over the same snapshot; it is only refreshed on a new address.
                    if (scl_rise) begin
                        if (!sda_s) begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            state_d    = TX;
                        end else begin
                            sda_out_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = IDLE;
                        end
                    end
                end
                IGNORE: begin
                    sda_out_d = 1'b1;
                end
                default: begin
                    state_d   = IDLE;
                    sda_out_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            byte_idx_q <= 2'd0;
            count_q    <= 8'd0;
            busy_q     <= 1'b0;
            sda_out_q  <= 1'b1;
            ack_drv_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            sda_out_q  <= sda_out_d;
            ack_drv_q  <= ack_drv_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q    <= shift_d;
        snap_q     <= snap_d;
        pad_meta_q <= pad_meta_d;
        pad_sync_q <= pad_sync_d;
    end

    // START/STOP let go of the line combinationally, ahead of the registered drive.
    assign sda_out = sda_out_q | start_det | stop_det;
    assign busy    = busy_q;

endmodule

// File: tb/tb_joypad_target.sv
// Bench for joypad_target: a bit-banged initiator on a wired-AND SDA line,
// with expected read bytes queued at stimulus time and popped as bytes arrive.
`timescale 1ns/1ps
module tb_joypad_target;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] p1    = 8'h81;
    logic [7:0] p2    = 8'h3C;
    logic [1:0] pres  = 2'b11;
    logic       sda_out;
    logic       busy;
    logic       sda_line;

    int         tests   = 0;
    int         fails   = 0;
    int         low_cnt = 0;
    logic [7:0] cnt     = 8'd0;
    logic [7:0] exp_q[$];

    assign sda_line = sda_m & sda_out;

    joypad_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl),
        .sda_in     (sda_line),
        .sda_out    (sda_out),
        .buttons_p1 (p1),
        .buttons_p2 (p2),
        .present    (pres),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Counts clocks during which the target pulls SDA low.
    always @(negedge clk) begin
        if (sda_out !== 1'b1) low_cnt <= low_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout, required finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SCL is low on entry and on exit; SDA only moves while SCL is low.
    task automatic send_bit(input logic b, output logic r);
        tick(2);
        sda_m = b;
        tick(4);
        scl = 1'b1;
        tick(3);
        r = sda_line;
        tick(3);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        tick(2);
        sda_m = 1'b1;
        tick(4);
        scl = 1'b1;
        tick(3);
        sda_m = 1'b0;
        tick(3);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(2);
        sda_m = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(3);
        sda_m = 1'b1;
        tick(3);
    endtask

    task automatic address(input logic [7:0] a, input logic exp_ack);
        logic r;
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(a[i], r);
        send_bit(1'b1, r);
        check("addr_ack", r, exp_ack);
        check("busy_after_addr", busy, !exp_ack);
        if (!exp_ack) cnt = cnt + 8'd1;
    endtask

    task automatic rd_byte(input logic mack);
        logic [7:0] got;
        logic       r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, r);
            got[i] = r;
        end
        send_bit(mack, r);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_underflow: observed byte 0x%0h, required a queued expectation", got);
        end else begin
            check("rd_byte", got, exp_q.pop_front());
        end
    endtask

    task automatic push_payload(input int n);
        for (int i = 0; i < n; i++) begin
            case (i % 4)
                0:       exp_q.push_back(p1);
                1:       exp_q.push_back(p2);
                2:       exp_q.push_back({6'b0, pres});
                default: exp_q.push_back(cnt);
            endcase
        end
    endtask

    task automatic read_txn(input int n);
        push_payload(n);
        address(8'hA5, 1'b0);
        for (int i = 0; i < n; i++) rd_byte(i == n - 1);
        check("busy_after_nack", busy, 0);
        stop_cond();
    endtask

    initial begin
        int   base;
        logic r;

        // Reset and idle line behaviour
        tick(4);
        check("reset_sda", sda_out, 1);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick(4);
        base = low_cnt;
        scl  = 1'b0;
        tick(2);
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), r);
        check("idle_no_drive", low_cnt - base, 0);
        check("idle_busy", busy, 0);

        // Basic reads and counter progression
        read_txn(4);
        read_txn(4);
        while (cnt != 8'hFF) begin
            address(8'hA5, 1'b0);
            stop_cond();
        end
        read_txn(4);
        read_txn(4);

        // Write address and foreign address are ignored
        base = low_cnt;
        address(8'hA4, 1'b1);
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), r);
        stop_cond();
        check("ignore_write_hold", low_cnt - base, 0);
        base = low_cnt;
        address(8'hB3, 1'b1);
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), r);
        stop_cond();
        check("ignore_other_hold", low_cnt - base, 0);

        // Buttons change after the snapshot; five bytes wrap onto the same snapshot
        push_payload(5);
        address(8'hA5, 1'b0);
        p1 = 8'h00;
        for (int i = 0; i < 5; i++) rd_byte(i == 4);
        check("busy_after_nack5", busy, 0);
        stop_cond();
        p1 = 8'h81;
        tick(4);

        // Repeated START while byte1 is on the line
        push_payload(1);
        address(8'hA5, 1'b0);
        rd_byte(1'b0);
        send_bit(1'b1, r);
        check("byte1_bit7", r, 0);
        send_bit(1'b1, r);
        check("byte1_bit6", r, 0);
        read_txn(4);

        // Asynchronous reset while byte1 bit7 (0) is being driven
        push_payload(1);
        address(8'hA5, 1'b0);
        rd_byte(1'b0);
        tick(5);
        check("drive_before_reset", sda_out, 0);
        rst_n = 1'b0;
        #1;
        check("reset_release_sda", sda_out, 1);
        check("reset_release_busy", busy, 0);
        tick(3);
        sda_m = 1'b1;
        scl   = 1'b1;
        rst_n = 1'b1;
        cnt   = 8'd0;
        tick(6);
        read_txn(4);

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/joypad_target.md
Name: joypad_target

Overview:
- Joypad-side responder for the two-wire serial link that `nes_bridge` drives as initiator. Sits on the controller end of the link.
- Samples two 8-button controller ports and answers read transactions addressed to it.
- Returns four data bytes in fixed order: P1 buttons, P2 buttons, presence flags, transaction count.
- Lets the SoC bridge, and the verification bench, exercise the full joypad path without a physical controller.

Parameters:
- TARGET_ADDR, 7'h52, 7-bit link address this block answers to.
- SYNC_STAGES, 2, flip-flop stages on `scl_in` and `sda_in` before edge detection; minimum 2.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  serial clock from the initiator.
- sda_in  input  1  serial data line as seen at the pad.
- sda_out  output  1  line drive: 0 pulls SDA low, 1 releases it (open-drain intent).
- buttons_p1  input  8  controller 1 buttons, 1 = pressed; asynchronous to clk.
- buttons_p2  input  8  controller 2 buttons, 1 = pressed.
- present  input  2  connection flags: bit0 = P1, bit1 = P2.
- busy  output  1  high from address-match until STOP or NACK.

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- Reset values:
  - `sda_out` = 1, `busy` = 0, state = IDLE.
  - Transaction counter = 0, byte index = 0.
  - Synchronizer flops reset to 1.
- Input conditioning:
  - `scl_in` and `sda_in` pass through SYNC_STAGES flops, then one history flop each.
  - Edges are detected on the synced signals only.
- Line conditions:
  - START: SDA falls while synced SCL is high.
  - STOP: SDA rises while synced SCL is high.
  - Both are evaluated in every state and override all other transitions:
    - START → ADDR, bit counter = 0; this also covers repeated START mid-byte.
    - STOP → IDLE.
  - Either one releases `sda_out` in the same cycle it is detected.
- Bit sampling and driving:
  - Sample SDA on the SCL rising edge.
  - Change `sda_out` exactly one clk after the SCL falling edge is detected, never while SCL is high.
- IDLE: wait for START.
- ADDR: shift 8 bits MSB-first (7 address bits + R/W).
  - After the 8th rising edge, a match requires address == TARGET_ADDR and R/W = 1. Match → ADDR_ACK.
  - Address mismatch, or R/W = 0 (writes unsupported) → IGNORE.
- ADDR_ACK:
  - On the next SCL fall, drive 0 for one SCL period.
  - Snapshot shift registers in the same cycle ACK begins:
    - byte0 = `buttons_p1`
    - byte1 = `buttons_p2`
    - byte2 = {6'b0, `present`}
    - byte3 = counter value before increment
  - Increment the counter (8-bit, wraps 255 → 0). Set `busy` = 1, byte index = 0.
  - On the SCL fall ending ACK → TX.
- TX:
  - Drive the 8 bits of snapshot[byte index] MSB-first; the first bit is driven on the SCL fall ending ACK.
  - After the 8th bit's SCL fall, release SDA → MACK.
- MACK: sample SDA on the SCL rise.
  - 0 (ACK): byte index += 1, wrapping 3 → 0; the snapshot is NOT refreshed on wrap. Return to TX.
  - 1 (NACK): release SDA, `busy` = 0 → IDLE.
- IGNORE: `sda_out` held at 1; wait for START or STOP.
- Button inputs may change at any time; only the snapshot is transmitted, so a multi-byte read is always self-consistent.
- `rst_n` asserted mid-transaction releases SDA immediately, since the reset is asynchronous.

Decomposition:
- Shared link package (also used by `nes_bridge`):
  - State enum: IDLE, ADDR, ADDR_ACK, TX, MACK, IGNORE.
  - Default TARGET_ADDR constant.
  - Payload byte-index constants: BYTE_P1 = 0, BYTE_P2 = 1, BYTE_STATUS = 2, BYTE_COUNT = 3.
- One sub-module, `line_sync_edge`: parameterized synchronizer plus rise/fall edge detector, instantiated once each for SCL and SDA.

Test Plan:
- Reset held, then released with lines idle → `sda_out` = 1 and `busy` = 0 throughout; no ACK on random SCL toggles without a START.
- START, 0xA5 (0x52 read), P1 = 0x81, P2 = 0x3C, present = 2'b11, master ACKs ×3 then NACKs → ACK = 0; bytes read 0x81, 0x3C, 0x03, 0x00; `busy` falls after the NACK.
- Repeat the read → count byte = 0x01. Preload 255 reads, then read → count byte = 0xFF, and the following read returns 0x00.
- Address 0xA4 (write) or 0xB3 → ACK bit reads 1; `sda_out` stays 1 until STOP.
- Change `buttons_p1` 0x81 → 0x00 mid-byte0, then ACK 5 bytes → bytes 0x81, 0x3C, 0x03, n, 0x81 (wrap uses the same snapshot).
- Repeated START during byte1, and separately `rst_n` low during byte1 → `sda_out` releases within one clk; a new 0xA5 is ACKed normally.
